exec_wb_seq: RTL and testbench

EXEC_WB_SEQ -- requirements
Module: exec_wb_seq

---
 rtl/exec_pkg.sv | 32 +++
 rtl/exec_alu.sv | 51 +++++
 rtl/exec_wb_seq.sv | 134 +++++++++++++
 tb/tb_exec_wb_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execute/writeback sequencer: opcodes, FSM states and
// the unary-op classifier used to skip the second register read.
package exec_pkg;

   localparam int unsigned OP_W    = 3;
   localparam int unsigned STATE_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_MOV = 3'b111
   } op_e;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 3'd0,
      S_READA = 3'd1,
      S_READB = 3'd2,
      S_EXEC  = 3'd3,
      S_WRITE = 3'd4
   } state_e;

   // Unary ops only consume operand A, so READB is skipped for them.
   function automatic logic is_unary(input op_e op);
      return (op == OP_NOT) || (op == OP_SHL) || (op == OP_MOV);
   endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for exec_wb_seq. Carry logic exists only when
// EXEC_FLAGS_EN is defined; otherwise carry is a constant 0.
module exec_alu
   import exec_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  op_e               op,
   input  logic [DATA_W-1:0] opA,
   input  logic [DATA_W-1:0] opB,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;

   assign sum  = opA + opB;
   assign diff = opA - opB;

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = sum;
         OP_SUB:  result = diff;
         OP_AND:  result = opA & opB;
         OP_OR:   result = opA | opB;
         OP_XOR:  result = opA ^ opB;
         OP_NOT:  result = ~opA;
         OP_SHL:  result = opA << 1;
         OP_MOV:  result = opA;
         default: result = '0;
      endcase
   end

`ifdef EXEC_FLAGS_EN
   // A wrapped sum is smaller than either addend exactly when the add carried out.
   always_comb begin
      carry = 1'b0;
      case (op)
         OP_ADD:  carry = (sum < opA);
         OP_SUB:  carry = (opA < opB);
         OP_SHL:  carry = opA[DATA_W-1];
         default: carry = 1'b0;
      endcase
   end
`else
   assign carry = 1'b0;
`endif

endmodule

// File: rtl/exec_wb_seq.sv
// Multi-cycle read/execute/writeback sequencer around a single-read-port
// register file. Define EXEC_FLAGS_EN to build the Zero/Carry status flags.
module exec_wb_seq
   import exec_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InstrValid,
   output logic              InstrReady,
   input  logic [2:0]        InstrOp,
   input  logic [ADDR_W-1:0] InstrDst,
   input  logic [ADDR_W-1:0] InstrSrcA,
   input  logic [ADDR_W-1:0] InstrSrcB,
   output logic [ADDR_W-1:0] ReadRegAddr,
   input  logic [DATA_W-1:0] ReadRegData,
   output logic [ADDR_W-1:0] WriteRegAddr,
   output logic [DATA_W-1:0] WriteRegData,
   output logic              WriteEnable,
   output logic              Busy,
   output logic              Done,
   output logic              ZeroFlag,
   output logic              CarryFlag
);

   state_e            state;
   op_e               op_q;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W-1:0] srcb_q;
   logic [DATA_W-1:0] opa_q;
   logic [DATA_W-1:0] opb_q;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;

   exec_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (op_q),
      .opA    (opa_q),
      .opB    (opb_q),
      .result (alu_result),
      .carry  (alu_carry)
   );

   // Sequencer; every output is set one edge ahead so it is stable for the whole state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= S_IDLE;
         op_q         <= OP_ADD;
         dst_q        <= '0;
         srcb_q       <= '0;
         opa_q        <= '0;
         opb_q        <= '0;
         InstrReady   <= 1'b1;
         Busy         <= 1'b0;
         Done         <= 1'b0;
         WriteEnable  <= 1'b0;
         WriteRegAddr <= '0;
         WriteRegData <= '0;
         ReadRegAddr  <= '0;
      end else begin
         Done        <= 1'b0;
         WriteEnable <= 1'b0;
         case (state)
            S_IDLE: begin
               if (InstrValid && InstrReady) begin
                  op_q        <= op_e'(InstrOp);
                  dst_q       <= InstrDst;
                  srcb_q      <= InstrSrcB;
                  ReadRegAddr <= InstrSrcA;
                  InstrReady  <= 1'b0;
                  Busy        <= 1'b1;
                  state       <= S_READA;
               end
            end
            S_READA: begin
               opa_q <= ReadRegData;
               if (is_unary(op_q)) begin
                  ReadRegAddr <= '0;
                  state       <= S_EXEC;
               end else begin
                  ReadRegAddr <= srcb_q;
                  state       <= S_READB;
               end
            end
            S_READB: begin
               opb_q       <= ReadRegData;
               ReadRegAddr <= '0;
               state       <= S_EXEC;
            end
            S_EXEC: begin
               WriteRegData <= alu_result;
               WriteRegAddr <= dst_q;
               WriteEnable  <= 1'b1;
               Done         <= 1'b1;
               state        <= S_WRITE;
            end
            S_WRITE: begin
               InstrReady <= 1'b1;
               Busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               InstrReady  <= 1'b1;
               Busy        <= 1'b0;
               ReadRegAddr <= '0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

`ifdef EXEC_FLAGS_EN
   logic carry_q;

   // Flags commit at the end of WRITE, so an abandoned instruction never touches them.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         carry_q   <= 1'b0;
         ZeroFlag  <= 1'b0;
         CarryFlag <= 1'b0;
      end else if (state == S_EXEC) begin
         carry_q <= alu_carry;
      end else if (state == S_WRITE) begin
         ZeroFlag  <= (WriteRegData == '0);
         CarryFlag <= carry_q;
      end
   end
`else
   assign ZeroFlag  = 1'b0;
   assign CarryFlag = alu_carry;
`endif

endmodule

// File: tb/tb_exec_wb_seq.sv
// Scoreboard bench for exec_wb_seq: stimulus pushes expected writebacks,
// a negedge monitor pops and compares them. Honours EXEC_FLAGS_EN.
module tb_exec_wb_seq;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
   localparam logic [2:0] XOR_ = 3'b100, NOT_ = 3'b101, SHL = 3'b110, MOV = 3'b111;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       InstrValid;
   logic       InstrReady;
   logic [2:0] InstrOp;
   logic [2:0] InstrDst, InstrSrcA, InstrSrcB;
   logic [2:0] ReadRegAddr;
   logic [7:0] ReadRegData;
   logic [2:0] WriteRegAddr;
   logic [7:0] WriteRegData;
   logic       WriteEnable, Busy, Done, ZeroFlag, CarryFlag;

   exec_wb_seq #(.DATA_W(8), .ADDR_W(3)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .InstrValid   (InstrValid),
      .InstrReady   (InstrReady),
      .InstrOp      (InstrOp),
      .InstrDst     (InstrDst),
      .InstrSrcA    (InstrSrcA),
      .InstrSrcB    (InstrSrcB),
      .ReadRegAddr  (ReadRegAddr),
      .ReadRegData  (ReadRegData),
      .WriteRegAddr (WriteRegAddr),
      .WriteRegData (WriteRegData),
      .WriteEnable  (WriteEnable),
      .Busy         (Busy),
      .Done         (Done),
      .ZeroFlag     (ZeroFlag),
      .CarryFlag    (CarryFlag)
   );

   always #5 Clk = ~Clk;

   logic [7:0] regs [8];
   assign ReadRegData = regs[ReadRegAddr];

   typedef struct {
      logic [2:0] addr;
      logic [7:0] data;
      logic       z;
      logic       c;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   we_cnt = 0;
   logic fl_pend = 1'b0;
   logic fz, fc;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: writeback contents/latency on the WRITE cycle, flags one cycle later.
   always @(negedge Clk) begin
      if (fl_pend) begin
         check("zero_flag", 32'(ZeroFlag), 32'(fz));
         check("carry_flag", 32'(CarryFlag), 32'(fc));
         fl_pend = 1'b0;
      end
      if (WriteEnable === 1'b1) begin
         we_cnt++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h, required no write", WriteRegAddr, WriteRegData);
         end else begin
            e = sb.pop_front();
            check("wr_addr", 32'(WriteRegAddr), 32'(e.addr));
            check("wr_data", 32'(WriteRegData), 32'(e.data));
            check("done_with_we", 32'(Done), 32'd1);
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
`ifdef EXEC_FLAGS_EN
            fz = e.z;
            fc = e.c;
`else
            fz = 1'b0;
            fc = 1'b0;
`endif
            fl_pend = 1'b1;
         end
      end
   end

   // Called at a negedge; returns at the negedge of the READA cycle.
   task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] a,
                        input logic [2:0] b, input logic [7:0] data, input logic z,
                        input logic c, input bit hold, input bit push, output int acc);
      bit ok = 0;
      InstrOp = op; InstrDst = d; InstrSrcA = a; InstrSrcB = b; InstrValid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (InstrReady === 1'b1) begin ok = 1; break; end
         @(negedge Clk);
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: InstrReady stayed %b, required 1", InstrReady);
         InstrValid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      if (push) sb.push_back('{d, data, z, c, (op >= 3'd5) ? 2 : 3, acc});
      @(posedge Clk);
      @(negedge Clk);
      if (!hold) InstrValid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0 && InstrReady === 1'b1 && !fl_pend) begin ok = 1; break; end
         @(negedge Clk);
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL done_timeout: %0d writebacks outstanding, required 0", sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc1, acc2, we0;
      regs[0] = 8'h03; regs[1] = 8'h81; regs[2] = 8'hFF; regs[3] = 8'h01;
      regs[4] = 8'h40; regs[5] = 8'h05; regs[6] = 8'h06; regs[7] = 8'h3C;
      Reset = 1'b1; InstrValid = 1'b0; InstrOp = '0;
      InstrDst = '0; InstrSrcA = '0; InstrSrcB = '0;
      repeat (3) @(negedge Clk);
      check("rst_ready", 32'(InstrReady), 32'd1);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_we", 32'(WriteEnable), 32'd0);
      check("rst_waddr", 32'(WriteRegAddr), 32'd0);
      check("rst_wdata", 32'(WriteRegData), 32'd0);
      check("rst_raddr", 32'(ReadRegAddr), 32'd0);
      check("rst_zero", 32'(ZeroFlag), 32'd0);
      check("rst_carry", 32'(CarryFlag), 32'd0);

      // Reset wins over an accept in the same cycle.
      InstrValid = 1'b1;
      @(negedge Clk);
      Reset = 1'b0; InstrValid = 1'b0;
      check("rst_vs_accept_busy", 32'(Busy), 32'd0);
      check("rst_vs_accept_ready", 32'(InstrReady), 32'd1);

      // ADD r7 = r5 + r6 with read-address sequencing checks.
      issue(ADD, 3'd7, 3'd5, 3'd6, 8'h0B, 1'b0, 1'b0, 0, 1, acc1);
      check("reada_addr", 32'(ReadRegAddr), 32'd5);
      check("reada_busy", 32'(Busy), 32'd1);
      check("reada_ready", 32'(InstrReady), 32'd0);
      @(negedge Clk);
      check("readb_addr", 32'(ReadRegAddr), 32'd6);
      @(negedge Clk);
      check("exec_addr", 32'(ReadRegAddr), 32'd0);
      check("exec_we", 32'(WriteEnable), 32'd0);
      wait_done();

      issue(ADD,  3'd1, 3'd2, 3'd3, 8'h00, 1'b1, 1'b1, 0, 1, acc1); wait_done();
      issue(SUB,  3'd4, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0, 0, 1, acc1); wait_done();
      issue(SHL,  3'd2, 3'd1, 3'd0, 8'h02, 1'b0, 1'b1, 0, 1, acc1); wait_done();
      issue(SUB,  3'd3, 3'd3, 3'd5, 8'hFC, 1'b0, 1'b1, 0, 1, acc1); wait_done();
      issue(AND_, 3'd5, 3'd7, 3'd2, 8'h3C, 1'b0, 1'b0, 0, 1, acc1); wait_done();
      issue(OR_,  3'd6, 3'd7, 3'd4, 8'h7C, 1'b0, 1'b0, 0, 1, acc1); wait_done();
      issue(XOR_, 3'd0, 3'd7, 3'd7, 8'h00, 1'b1, 1'b0, 0, 1, acc1); wait_done();
      issue(NOT_, 3'd1, 3'd7, 3'd0, 8'hC3, 1'b0, 1'b0, 0, 1, acc1); wait_done();
      issue(SHL,  3'd3, 3'd4, 3'd0, 8'h80, 1'b0, 1'b0, 0, 1, acc1); wait_done();
      issue(ADD,  3'd5, 3'd5, 3'd5, 8'h0A, 1'b0, 1'b0, 0, 1, acc1); wait_done();
      issue(MOV,  3'd7, 3'd4, 3'd0, 8'h40, 1'b0, 1'b0, 0, 1, acc1); wait_done();

      // Reset during READB abandons the instruction; flags stay at 0 from the MOV.
      we0 = we_cnt;
      issue(ADD, 3'd1, 3'd5, 3'd6, 8'h0B, 1'b0, 1'b0, 0, 0, acc1);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check("abort_ready", 32'(InstrReady), 32'd1);
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_done", 32'(Done), 32'd0);
      check("abort_we", 32'(WriteEnable), 32'd0);
      check("abort_zero", 32'(ZeroFlag), 32'd0);
      check("abort_carry", 32'(CarryFlag), 32'd0);
      repeat (6) @(negedge Clk);
      check("abort_no_write", 32'(we_cnt - we0), 32'd0);

      // InstrValid held high across two back-to-back ADDs.
      we0 = we_cnt;
      issue(ADD, 3'd1, 3'd5, 3'd6, 8'h0B, 1'b0, 1'b0, 1, 1, acc1);
      issue(ADD, 3'd2, 3'd2, 3'd3, 8'h00, 1'b1, 1'b1, 0, 1, acc2);
      check("b2b_accept_cycle", 32'(acc2), 32'(acc1 + 5));
      wait_done();
      repeat (4) @(negedge Clk);
      check("b2b_write_count", 32'(we_cnt - we0), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
